dmem_arbiter: RTL

Shares the single data-memory port of the single-cycle RISC-V core between the CPU load/store path and the UART RX buffer write-back engine. It issues one access per memory cycle, returns read data one cycle after issue, and stalls the CPU while the port is busy. It sits between the core's memory-address, write-data and read-data signals and the data RAM.

---
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU load/store path vs UART RX write-back engine.
// Optional fairness (wait counter + starve override) enabled by DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter #(
  parameter int unsigned UART_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wmask,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        uart_req,
  input  logic        uart_we,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  output logic        uart_gnt,
  output logic [31:0] uart_rdata,
  output logic        uart_rvalid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  if (UART_MAX_WAIT < 1 || UART_MAX_WAIT > 15) begin : g_bad_max_wait
    $error("dmem_arbiter: UART_MAX_WAIT must be 1..15");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CPU  = 2'd1,
    RD_UART = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } acc_t;

  state_e state_q, state_d;
  acc_t   cpu_acc, uart_acc, win;
  logic   uart_win;
  logic   starve;

  assign cpu_acc  = '{we: cpu_we,  addr: cpu_addr,  wdata: cpu_wdata,  wmask: cpu_wmask};
  assign uart_acc = '{we: uart_we, addr: uart_addr, wdata: uart_wdata, wmask: 4'hF};

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam logic [3:0] MAX_W = 4'(UART_MAX_WAIT);

  logic [3:0] wait_q, wait_d;

  // Counts cycles the UART has been refused; saturates so starve stays asserted.
  always_comb begin
    wait_d = wait_q;
    if (uart_gnt)
      wait_d = 4'd0;
    else if (uart_req && wait_q != MAX_W)
      wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= 4'd0;
    else       wait_q <= wait_d;
  end

  assign starve = (wait_q == MAX_W);
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // IDLE outputs are combinational from the requests; reset gates them off
  // so nothing is issued while reset is held.
  always_comb begin
    state_d     = state_q;
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    cpu_rvalid  = 1'b0;
    uart_gnt    = 1'b0;
    uart_rdata  = '0;
    uart_rvalid = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    uart_win    = 1'b0;
    win         = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          uart_win = uart_req && (!cpu_req || starve);
          if (uart_win) begin
            win       = uart_acc;
            uart_gnt  = 1'b1;
            cpu_stall = cpu_req;
            if (!uart_we) state_d = RD_UART;
          end else if (cpu_req) begin
            win       = cpu_acc;
            cpu_stall = !cpu_we;
            if (!cpu_we) state_d = RD_CPU;
          end
          if (uart_win || cpu_req) begin
            mem_en    = 1'b1;
            mem_we    = win.we;
            mem_addr  = win.addr & ~32'h3;
            mem_wdata = win.wdata;
            mem_wmask = win.wmask;
          end
        end
        RD_CPU: begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = mem_rdata;
          state_d    = IDLE;
        end
        RD_UART: begin
          uart_rvalid = 1'b1;
          uart_rdata  = mem_rdata;
          cpu_stall   = cpu_req;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
